// File: rtl/iob_2p_mem_tiled_arb_pkg.sv
// Shared constants and helpers for the tiled two-port memory request arbiter.
package iob_2p_mem_tiled_arb_pkg;

    // Grant encoding, also used as the encoding of the round-robin "last" register.
    localparam logic GNT_W = 1'b0;
    localparam logic GNT_R = 1'b1;

    // Read-response buffer geometry.
    localparam int RSP_DEPTH = 2;
    localparam int OCC_W     = 2;

    // Which request, if any, owns the memory this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_W    = 2'd1,
        SEL_R    = 2'd2
    } gnt_sel_e;

    // A read may issue only if every response already owed (buffered plus in
    // flight, less the one leaving this cycle) still leaves a free buffer slot.
    function automatic logic rd_eligible(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [OCC_W:0] owed;
        owed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
        return (owed < 3'd2);
    endfunction

endpackage

// File: rtl/iob_2p_mem_tiled_rsp_buf.sv
// Two-entry register FIFO holding read data until the response consumer takes it.
module iob_2p_mem_tiled_rsp_buf
    import iob_2p_mem_tiled_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [OCC_W-1:0]  occ_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic [DATA_W-1:0] entry_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;
    logic              push_en_s;
    logic              pop_en_s;

    // Qualify push/pop so the FIFO can never over- or underflow on its own.
    always_comb begin
        pop_en_s  = pop_i & (occ_q != 2'd0);
        push_en_s = push_i & ((occ_q != 2'd2) | pop_en_s);
    end

    // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_d = occ_q;
        case ({push_en_s, pop_en_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage, pointers and occupancy; reset clears the data so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            if (push_en_s) begin
                entry_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop_en_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = entry_q[rd_ptr_q];

endmodule

// File: rtl/iob_2p_mem_tiled_arb.sv
// Arbiter in front of the tiled two-port memory: one write or one read per
// cycle, round-robin when both contend, read data returned through a 2-deep
// response buffer with valid/ready handshake.
module iob_2p_mem_tiled_arb
    import iob_2p_mem_tiled_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_valid,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              r_valid,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    logic             inflight_q;
    logic             inflight_d;
    logic             last_q;
    logic             last_d;
    logic [OCC_W-1:0] occ_s;
    logic             pop_s;
    logic             r_elig_s;
    gnt_sel_e         sel_s;

    assign rd_valid = (occ_s != 2'd0);
    assign pop_s    = rd_valid & rd_ready;
    assign r_elig_s = rd_eligible(occ_s, inflight_q, pop_s);

    // Grant selection: lone eligible request wins; on contention the side
    // that did not win last time is served. Nothing is granted during reset.
    always_comb begin
        sel_s = SEL_NONE;
        if (rst) begin
            sel_s = SEL_NONE;
        end else begin
            case ({w_valid, r_valid & r_elig_s})
                2'b11:   sel_s = (last_q == GNT_R) ? SEL_W : SEL_R;
                2'b10:   sel_s = SEL_W;
                2'b01:   sel_s = SEL_R;
                default: sel_s = SEL_NONE;
            endcase
        end
    end

    // Memory-side strobes and address mux; write data is always presented.
    always_comb begin
        w_ready     = (sel_s == SEL_W);
        r_ready     = (sel_s == SEL_R);
        mem_w_en    = w_valid & w_ready;
        mem_r_en    = r_valid & r_ready;
        mem_addr    = (sel_s == SEL_R) ? r_addr : w_addr;
        mem_data_in = w_data;
    end

    // Next-state for round-robin history and the in-flight read marker. A
    // capture always clears the marker, a new issue always sets it, so the
    // marker simply follows the read strobe.
    always_comb begin
        last_d     = last_q;
        inflight_d = mem_r_en;
        case (sel_s)
            SEL_W:   last_d = GNT_W;
            SEL_R:   last_d = GNT_R;
            default: last_d = last_q;
        endcase
    end

    // Arbiter state registers; reset discards any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            last_q     <= GNT_R;
        end else begin
            inflight_q <= inflight_d;
            last_q     <= last_d;
        end
    end

    iob_2p_mem_tiled_rsp_buf #(
        .DATA_W (DATA_W)
    ) u_rsp_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (inflight_q),
        .push_data_i (mem_data_out),
        .pop_i       (pop_s),
        .occ_o       (occ_s),
        .head_o      (rd_data)
    );

endmodule

// File: tb/tb_iob_2p_mem_tiled_arb.sv
// Directed self-checking bench for iob_2p_mem_tiled_arb with a memory model
// and a read-response scoreboard.
module tb_iob_2p_mem_tiled_arb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 15;
    localparam int MEM_N  = 32768;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_valid = 1'b0;
    logic [ADDR_W-1:0] w_addr = '0;
    logic [DATA_W-1:0] w_data = '0;
    logic              w_ready;
    logic              r_valid = 1'b0;
    logic [ADDR_W-1:0] r_addr = '0;
    logic              r_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready = 1'b1;
    logic              mem_w_en;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out = '0;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mem_m   [MEM_N];
    bit                mem_vld [MEM_N];
    logic [DATA_W-1:0] ref_m   [MEM_N];
    bit                ref_vld [MEM_N];

    iob_2p_mem_tiled_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_valid      (w_valid),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .r_valid      (r_valid),
        .r_addr       (r_addr),
        .r_ready      (r_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .mem_w_en     (mem_w_en),
        .mem_r_en     (mem_r_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Contents of a never-written location, distinct per address.
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {2'b10, a, ~a};
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            step();
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    // Memory model: registered read data, written at the edge ending the grant.
    always @(posedge clk) begin
        if (mem_w_en) begin
            mem_m[mem_addr]   <= mem_data_in;
            mem_vld[mem_addr] <= 1'b1;
        end
        if (mem_r_en) begin
            mem_data_out <= mem_vld[mem_addr] ? mem_m[mem_addr] : init_val(mem_addr);
        end
    end

    // Scoreboard: record accepted writes, push expected data for accepted
    // reads, compare delivered responses in order. Reset forgets owed reads.
    always @(negedge clk) begin
        chk("strobe_excl", {31'd0, mem_w_en & mem_r_en}, 32'd0);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, rd_valid}, 32'd0);
                end else begin
                    chk("rsp_data", rd_data, exp_q.pop_front());
                end
            end
            if (w_valid && w_ready) begin
                ref_m[w_addr]   = w_data;
                ref_vld[w_addr] = 1'b1;
            end
            if (r_valid && r_ready) begin
                exp_q.push_back(ref_vld[r_addr] ? ref_m[r_addr] : init_val(r_addr));
            end
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int accepted;

        // Reset held with both requests pending.
        rst      = 1'b1;
        w_valid  = 1'b1;
        r_valid  = 1'b1;
        rd_ready = 1'b1;
        w_addr   = 15'h0100;
        w_data   = 32'h1111_2222;
        r_addr   = 15'h0100;
        for (int i = 0; i < 3; i++) begin
            step();
            settle();
            chk("rst_w_ready", {31'd0, w_ready}, 32'd0);
            chk("rst_r_ready", {31'd0, r_ready}, 32'd0);
            chk("rst_mem_w_en", {31'd0, mem_w_en}, 32'd0);
            chk("rst_mem_r_en", {31'd0, mem_r_en}, 32'd0);
            chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
            chk("rst_rd_data", rd_data, 32'd0);
        end

        // First contended cycle after reset goes to the write, next to the read.
        step();
        rst = 1'b0;
        settle();
        chk("post_rst_w_ready", {31'd0, w_ready}, 32'd1);
        chk("post_rst_r_ready", {31'd0, r_ready}, 32'd0);
        chk("post_rst_mem_w_en", {31'd0, mem_w_en}, 32'd1);
        step();
        w_valid = 1'b0;
        settle();
        chk("post_rst_rd_grant", {31'd0, r_ready}, 32'd1);
        step();
        r_valid = 1'b0;

        // Write 0x10 then read it back; response exactly two cycles after grant.
        step();
        w_valid = 1'b1;
        w_addr  = 15'h0010;
        w_data  = 32'hDEAD_BEEF;
        settle();
        chk("wr_grant", {31'd0, w_ready}, 32'd1);
        chk("wr_mem_addr", {17'd0, mem_addr}, 32'h0000_0010);
        chk("wr_mem_data", mem_data_in, 32'hDEAD_BEEF);
        step();
        w_valid = 1'b0;
        r_valid = 1'b1;
        r_addr  = 15'h0010;
        settle();
        chk("rd_grant", {31'd0, r_ready}, 32'd1);
        chk("rd_mem_r_en", {31'd0, mem_r_en}, 32'd1);
        chk("rd_mem_addr", {17'd0, mem_addr}, 32'h0000_0010);
        step();
        r_valid = 1'b0;
        settle();
        chk("rd_lat_n1", {31'd0, rd_valid}, 32'd0);
        step();
        settle();
        chk("rd_lat_n2", {31'd0, rd_valid}, 32'd1);
        chk("rd_data_new", rd_data, 32'hDEAD_BEEF);
        drain("drain_wr_rd");

        // Contention: six cycles of both valid alternate W,R,W,R,W,R.
        for (int i = 0; i < 6; i++) begin
            step();
            w_valid = 1'b1;
            r_valid = 1'b1;
            w_addr  = 15'h0020 + ADDR_W'(i);
            w_data  = $urandom;
            r_addr  = 15'h0020 + ADDR_W'(i);
            settle();
            chk("cont_w_ready", {31'd0, w_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_r_ready", {31'd0, r_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        step();
        w_valid = 1'b0;
        r_valid = 1'b0;
        drain("drain_cont");

        // Backpressure: five reads with rd_ready low, only two get in.
        rd_ready = 1'b0;
        k        = 0;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            r_valid = (k < 5);
            r_addr  = ADDR_W'(k);
            settle();
            if (r_valid && r_ready) begin
                k++;
                accepted++;
            end
        end
        chk("bp_accepted", accepted, 32'd2);
        chk("bp_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("bp_r_ready_low", {31'd0, r_ready}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            rd_ready = 1'b1;
            r_valid  = (k < 5);
            r_addr   = ADDR_W'(k);
            settle();
            chk("bp_stream_valid", {31'd0, rd_valid}, 32'd1);
            if (r_valid && r_ready) begin
                k++;
            end
        end
        chk("bp_all_issued", k, 32'd5);
        step();
        r_valid = 1'b0;
        drain("drain_bp");

        // Streaming: eight back-to-back reads, eight consecutive responses.
        for (int i = 0; i < 8; i++) begin
            step();
            r_valid = 1'b1;
            r_addr  = 15'h0040 + ADDR_W'(i);
            settle();
            chk("stream_r_ready", {31'd0, r_ready}, 32'd1);
            if (i >= 2) begin
                chk("stream_rd_valid", {31'd0, rd_valid}, 32'd1);
            end
        end
        step();
        r_valid = 1'b0;
        settle();
        chk("stream_tail6", {31'd0, rd_valid}, 32'd1);
        step();
        settle();
        chk("stream_tail7", {31'd0, rd_valid}, 32'd1);
        step();
        settle();
        chk("stream_done", {31'd0, rd_valid}, 32'd0);
        drain("drain_stream");

        // Reset in the cycle after a read grant: the response must vanish.
        step();
        r_valid = 1'b1;
        r_addr  = 15'h0050;
        settle();
        chk("mid_rst_grant", {31'd0, r_ready}, 32'd1);
        step();
        rst     = 1'b1;
        r_valid = 1'b0;
        settle();
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("mid_rst_no_rsp", {31'd0, rd_valid}, 32'd0);
            step();
        end
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_2p_mem_tiled_arb.md
# iob_2p_mem_tiled_arb

Request arbiter and read-response buffer placed directly upstream of the tiled two-port memory. The memory exposes a single shared address bus with `w_en`/`r_en` and one-cycle registered read data. This block turns independent valid/ready write and read request channels into at most one memory operation per cycle. It captures read data into a 2-entry buffer and returns it on a valid/ready response channel, so masters never need to track memory latency.

## Interface
- `DATA_W`, 32: data width; must equal the memory's data width.
- `ADDR_W`, 15: memory address width; `mem_addr` is passed through unchanged.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `w_valid`  in  1: write request valid.
- `w_addr`  in  ADDR_W: write address.
- `w_data`  in  DATA_W: write data.
- `w_ready`  out  1: write accepted this cycle.
- `r_valid`  in  1: read request valid.
- `r_addr`  in  ADDR_W: read address.
- `r_ready`  out  1: read accepted this cycle.
- `rd_valid`  out  1: read response valid.
- `rd_data`  out  DATA_W: read response data.
- `rd_ready`  in  1: response consumer ready.
- `mem_w_en`, `mem_r_en`  out  1: memory strobes.
- `mem_addr`  out  ADDR_W: shared memory address.
- `mem_data_in`  out  DATA_W: memory write data.
- `mem_data_out`  in  DATA_W: memory read data, valid the cycle after `mem_r_en`.

## Operation
- One grant per cycle; `w_ready`/`r_ready` are combinational grants.
- `mem_w_en = w_valid & w_ready`; `mem_r_en = r_valid & r_ready`. Never both high.
- `mem_addr` is the granted address, or `w_addr` when idle. `mem_data_in = w_data` always.
- Read eligibility: `occ + inflight - pop < 2`.
  - `occ` is buffer occupancy (0..2).
  - `inflight` is a 1-bit register set by `mem_r_en`.
  - `pop = rd_valid & rd_ready`.
  - `r_ready` therefore has a combinational path from `rd_ready`.
- Writes are always eligible.
- Arbitration:
  - If only one request is eligible and valid, grant it.
  - If both, round-robin on register `last`: grant the side not equal to `last`.
  - `last` updates on every grant.
- Capture: when `inflight` is 1, `mem_data_out` is pushed into the buffer at the clock edge and `inflight` clears unless a new read was issued.
- `rd_valid = (occ != 0)`; `rd_data` is the buffer head.
- Push and pop in the same cycle keep `occ` constant and order is preserved.
- Ordering is strict issue order. A read issued after a write to the same address returns the new data.

## Timing
- Reset values:
  - `occ=0`, `inflight=0`, `last=READ` (so the first contended grant goes to write).
  - Buffer pointers 0.
  - `rd_valid=0`, `w_ready=0`, `r_ready=0`, `mem_w_en=0`, `mem_r_en=0` while `rst` is high.
  - `rd_data=0` after reset.
- Read latency: accept at cycle N, memory data at N+1, `rd_valid` at N+2.
- Sustained read throughput is 1 per cycle while `rd_ready=1`.
- With `rd_ready=0`, at most 2 reads are outstanding (buffered plus in flight); `r_ready` then stays 0.
- Write latency: memory written at the edge ending the grant cycle.
- Reset mid-operation: the in-flight read is discarded, the buffer is emptied, and no `rd_valid` appears for requests made before reset.

## Structure
- Package `iob_2p_mem_tiled_arb_pkg`:
  - grant encoding constants `GNT_W=1'b0`, `GNT_R=1'b1`;
  - `RSP_DEPTH=2`;
  - `OCC_W=2`.
- Sub-module `iob_2p_mem_tiled_rsp_buf`: 2-entry register FIFO with push, pop, `occ`, head, and synchronous reset.
- The top level holds arbitration, the `inflight` and `last` registers, and the memory-side muxing.

## Test plan
- Reset: hold `rst` 3 cycles with `w_valid=r_valid=1` -> all grants and `mem_*_en` are 0, `rd_valid=0`. First post-reset cycle grants write.
- Write then read: write `addr=0x10`, `data=0xDEADBEEF`, next cycle read `0x10` -> `rd_data=0xDEADBEEF` with `rd_valid` exactly 2 cycles after `r_ready`.
- Contention: `w_valid`/`r_valid` held high for 6 cycles -> grants alternate W,R,W,R,W,R. Never both memory strobes high.
- Backpressure: `rd_ready=0` with 5 reads to addresses 0..4 -> exactly 2 accepted, `rd_valid=1`. Raise `rd_ready` -> data returns in order 0,1,2,3,4 at 1 per cycle.
- Streaming: `rd_ready=1`, 8 back-to-back reads -> `r_ready=1` every cycle, 8 responses on consecutive cycles.
- Reset mid-read: assert `rst` in the cycle after a read grant -> no response is delivered after reset deasserts.
